// File: rtl/mips_pkg.sv
// Shared MIPS definitions: access-size encodings and default widths.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;
    localparam int NB_ADDR_DEF = 8;

    // Load/store access size; the unused code 2'b10 behaves as a word.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b11
    } mem_size_e;

endpackage

// File: rtl/data_memory.sv
// Little-endian data memory: byte-enable synchronous write, combinational
// read port for the pipeline, registered read port for the debug unit.
module data_memory
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [3:0]           i_byte_en,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [NB_DATA-1:0]   i_wdata,
    output logic [NB_DATA-1:0]   o_rdata,
    input  logic [NB_ADDR-1:0]   i_debug_addr,
    output logic [NB_DATA-1:0]   o_debug_data
);

    // Contents start at zero and are deliberately not touched by reset.
    logic [NB_DATA-1:0] mem_q [0:(1<<NB_ADDR)-1] = '{default: '0};
    logic [NB_DATA-1:0] debug_data_d;
    logic [NB_DATA-1:0] debug_data_q;

    // Byte-lane write; lanes with a cleared enable keep their old value.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_byte_en[k]) begin
                mem_q[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    // Pipeline read sees the array before any write landing on this edge.
    always_comb begin
        o_rdata      = mem_q[i_addr];
        debug_data_d = mem_q[i_debug_addr];
    end

    // Debug read register; runs regardless of pipeline enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            debug_data_q <= '0;
        end else begin
            debug_data_q <= debug_data_d;
        end
    end

    assign o_debug_data = debug_data_q;

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores on the data memory,
// feeding the MEM/WB register. There is no handshake: the stage advances on
// every edge with i_enable=1 and freezes completely with i_enable=0.
module memory_access
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_REG  = NB_REG_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NB_DATA-1:0]   i_ALU_result,
    input  logic [NB_DATA-1:0]   i_data_to_write_in_MEM,
    input  logic [NB_REG-1:0]    i_write_reg,
    input  logic                 i_WB_write,
    input  logic                 i_WB_mem_to_reg,
    input  logic                 i_MEM_read,
    input  logic                 i_MEM_write,
    input  logic                 i_MEM_unsigned,
    input  logic [1:0]           i_MEM_byte_half_word,
    input  logic [NB_ADDR-1:0]   i_debug_addr,
    output logic                 o_WB_write,
    output logic                 o_WB_mem_to_reg,
    output logic [NB_REG-1:0]    o_write_reg,
    output logic [NB_DATA-1:0]   o_ALU_result,
    output logic [NB_DATA-1:0]   o_mem_data,
    output logic [NB_DATA-1:0]   o_debug_data
);

    logic [1:0]         lane;
    logic [NB_ADDR-1:0] word_idx;
    logic [3:0]         byte_en_raw;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] store_data;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] load_value;
    logic               unused_addr_bits;

    logic               wb_write_d, wb_write_q;
    logic               wb_mem_to_reg_d, wb_mem_to_reg_q;
    logic [NB_REG-1:0]  write_reg_d, write_reg_q;
    logic [NB_DATA-1:0] alu_result_d, alu_result_q;
    logic [NB_DATA-1:0] mem_data_d, mem_data_q;

    // Address bits above the memory wrap around and are ignored.
    assign unused_addr_bits = ^i_ALU_result[NB_DATA-1:NB_ADDR+2];

    // Lane decode and store-data replication; alignment is forced, not trapped.
    always_comb begin
        lane        = i_ALU_result[1:0];
        word_idx    = i_ALU_result[NB_ADDR+1:2];
        byte_en_raw = 4'b1111;
        store_data  = i_data_to_write_in_MEM;
        case (i_MEM_byte_half_word)
            SIZE_BYTE: begin
                byte_en_raw = 4'b0001 << lane;
                store_data  = {4{i_data_to_write_in_MEM[7:0]}};
            end
            SIZE_HALF: begin
                byte_en_raw = lane[1] ? 4'b1100 : 4'b0011;
                store_data  = {2{i_data_to_write_in_MEM[15:0]}};
            end
            default: begin
                byte_en_raw = 4'b1111;
                store_data  = i_data_to_write_in_MEM;
            end
        endcase
        byte_en = (i_MEM_write && i_enable && !i_reset) ? byte_en_raw : 4'b0000;
    end

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_byte_en    (byte_en),
        .i_addr       (word_idx),
        .i_wdata      (store_data),
        .o_rdata      (rd_word),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data)
    );

    // Load extraction: right-justify the selected lane, then zero/sign extend.
    always_comb begin
        byte_sel   = rd_word[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_value = rd_word;
        case (i_MEM_byte_half_word)
            SIZE_BYTE: load_value = {{24{~i_MEM_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_value = {{16{~i_MEM_unsigned & half_sel[15]}}, half_sel};
            default:   load_value = rd_word;
        endcase
    end

    // MEM/WB next-state: capture when enabled, hold otherwise.
    always_comb begin
        wb_write_d      = wb_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        write_reg_d     = write_reg_q;
        alu_result_d    = alu_result_q;
        mem_data_d      = mem_data_q;
        if (i_enable) begin
            wb_write_d      = i_WB_write;
            wb_mem_to_reg_d = i_WB_mem_to_reg;
            write_reg_d     = i_write_reg;
            alu_result_d    = i_ALU_result;
            mem_data_d      = i_MEM_read ? load_value : '0;
        end
    end

    // MEM/WB register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_write_q      <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            write_reg_q     <= '0;
            alu_result_q    <= '0;
            mem_data_q      <= '0;
        end else begin
            wb_write_q      <= wb_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            write_reg_q     <= write_reg_d;
            alu_result_q    <= alu_result_d;
            mem_data_q      <= mem_data_d;
        end
    end

    assign o_WB_write      = wb_write_q;
    assign o_WB_mem_to_reg = wb_mem_to_reg_q;
    assign o_write_reg     = write_reg_q;
    assign o_ALU_result    = alu_result_q;
    assign o_mem_data      = mem_data_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: loads, stores, freeze and reset behaviour.
module tb_memory_access;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] alu_result;
    logic [31:0] wr_data;
    logic [4:0]  write_reg;
    logic        wb_write;
    logic        wb_mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        mem_unsigned;
    logic [1:0]  mem_size;
    logic [7:0]  debug_addr;
    logic        o_wb_write;
    logic        o_wb_mem_to_reg;
    logic [4:0]  o_write_reg;
    logic [31:0] o_alu_result;
    logic [31:0] o_mem_data;
    logic [31:0] o_debug_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_bytes [4];

    // Clock and reset generation.
    always #5 clk = ~clk;

    memory_access dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_enable               (enable),
        .i_ALU_result           (alu_result),
        .i_data_to_write_in_MEM (wr_data),
        .i_write_reg            (write_reg),
        .i_WB_write             (wb_write),
        .i_WB_mem_to_reg        (wb_mem_to_reg),
        .i_MEM_read             (mem_read),
        .i_MEM_write            (mem_write),
        .i_MEM_unsigned         (mem_unsigned),
        .i_MEM_byte_half_word   (mem_size),
        .i_debug_addr           (debug_addr),
        .o_WB_write             (o_wb_write),
        .o_WB_mem_to_reg        (o_wb_mem_to_reg),
        .o_write_reg            (o_write_reg),
        .o_ALU_result           (o_alu_result),
        .o_mem_data             (o_mem_data),
        .o_debug_data           (o_debug_data)
    );

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic uns,
                          input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data);
        mem_read     = rd;
        mem_write    = wr;
        mem_unsigned = uns;
        mem_size     = sz;
        alu_result   = addr;
        wr_data      = data;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_bytes[0] = 32'hFFFF_FFEF;
        exp_bytes[1] = 32'hFFFF_FFBE;
        exp_bytes[2] = 32'hFFFF_FFAD;
        exp_bytes[3] = 32'hFFFF_FFDE;

        // Reset with live-looking inputs: outputs must still clear.
        reset = 1'b1; enable = 1'b1;
        wb_write = 1'b1; wb_mem_to_reg = 1'b1; write_reg = 5'd5;
        debug_addr = 8'd0;
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h33, 32'h0);
        step(); step();
        check("rst_wb_write", {31'b0, o_wb_write}, 32'h0);
        check("rst_mem_to_reg", {31'b0, o_wb_mem_to_reg}, 32'h0);
        check("rst_write_reg", {27'b0, o_write_reg}, 32'h0);
        check("rst_alu", o_alu_result, 32'h0);
        check("rst_mem_data", o_mem_data, 32'h0);
        check("rst_debug", o_debug_data, 32'h0);
        reset = 1'b0; wb_write = 1'b0; wb_mem_to_reg = 1'b0; write_reg = 5'd0;

        // Word store then word load.
        mem_op(1'b0, 1'b1, 1'b0, SZ_W, 32'h10, 32'hDEAD_BEEF);
        step();
        check("store_alu_pass", o_alu_result, 32'h10);
        check("store_mem_data_zero", o_mem_data, 32'h0);
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        debug_addr = 8'd4;
        step();
        check("word_load_10", o_mem_data, 32'hDEAD_BEEF);
        check("debug_idx4", o_debug_data, 32'hDEAD_BEEF);

        // Signed byte loads from each lane.
        for (int i = 0; i < 4; i++) begin
            mem_op(1'b1, 1'b0, 1'b0, SZ_B, 32'h10 + i, 32'h0);
            step();
            check($sformatf("byte_signed_%0d", i), o_mem_data, exp_bytes[i]);
        end
        mem_op(1'b1, 1'b0, 1'b1, SZ_B, 32'h13, 32'h0);
        step();
        check("byte_unsigned_13", o_mem_data, 32'h0000_00DE);

        // Half store into the upper half; upper bits of the data are ignored.
        mem_op(1'b0, 1'b1, 1'b0, SZ_H, 32'h12, 32'hFFFF_1234);
        step();
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        step();
        check("word_after_half", o_mem_data, 32'h1234_BEEF);
        mem_op(1'b1, 1'b0, 1'b0, SZ_H, 32'h10, 32'h0);
        step();
        check("half_signed_10", o_mem_data, 32'hFFFF_BEEF);
        mem_op(1'b1, 1'b0, 1'b1, SZ_H, 32'h12, 32'h0);
        step();
        check("half_unsigned_12", o_mem_data, 32'h0000_1234);
        mem_op(1'b1, 1'b0, 1'b0, SZ_H, 32'h11, 32'h0);
        write_reg = 5'd3; debug_addr = 8'd5;
        step();
        check("half_misaligned_11", o_mem_data, 32'hFFFF_BEEF);
        check("debug_idx5", o_debug_data, 32'h0);

        // Frozen stage: store suppressed, outputs held, debug port live.
        enable = 1'b0; write_reg = 5'd7; debug_addr = 8'd4;
        mem_op(1'b0, 1'b1, 1'b0, SZ_B, 32'h11, 32'h0000_00AB);
        step();
        check("hold_mem_data", o_mem_data, 32'hFFFF_BEEF);
        check("hold_write_reg", {27'b0, o_write_reg}, 32'd3);
        check("hold_alu", o_alu_result, 32'h11);
        check("debug_while_frozen", o_debug_data, 32'h1234_BEEF);
        enable = 1'b1;
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        step();
        check("no_store_when_frozen", o_mem_data, 32'h1234_BEEF);

        // Enabled byte store touches only its lane; high address bits wrap.
        mem_op(1'b0, 1'b1, 1'b0, SZ_B, 32'h11, 32'hFFFF_FF5A);
        step();
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h10, 32'h0);
        step();
        check("byte_store_lane1", o_mem_data, 32'h1234_5AEF);
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h410, 32'h0);
        step();
        check("addr_wrap", o_mem_data, 32'h1234_5AEF);

        // Simultaneous read and write: load sees pre-write contents.
        mem_op(1'b1, 1'b1, 1'b0, SZ_W, 32'h30, 32'hA5A5_0F0F);
        step();
        check("rw_same_old", o_mem_data, 32'h0);
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h30, 32'h0);
        step();
        check("rw_same_new", o_mem_data, 32'hA5A5_0F0F);

        // R-type pass-through.
        wb_write = 1'b1; wb_mem_to_reg = 1'b1; write_reg = 5'd9; debug_addr = 8'd21;
        mem_op(1'b0, 1'b0, 1'b0, SZ_W, 32'h55, 32'h0);
        step();
        check("rtype_wb_write", {31'b0, o_wb_write}, 32'h1);
        check("rtype_mem_to_reg", {31'b0, o_wb_mem_to_reg}, 32'h1);
        check("rtype_write_reg", {27'b0, o_write_reg}, 32'd9);
        check("rtype_alu", o_alu_result, 32'h55);
        check("rtype_mem_data", o_mem_data, 32'h0);
        check("rtype_mem_untouched", o_debug_data, 32'h0);

        // Store, then reset with a store pending.
        wb_write = 1'b0; wb_mem_to_reg = 1'b0; write_reg = 5'd0;
        mem_op(1'b0, 1'b1, 1'b0, SZ_B, 32'h20, 32'h0000_0077);
        debug_addr = 8'd4;
        step();
        reset = 1'b1; wb_write = 1'b1; write_reg = 5'd4;
        mem_op(1'b1, 1'b1, 1'b0, SZ_W, 32'h24, 32'hCAFE_F00D);
        step();
        check("mid_rst_wb_write", {31'b0, o_wb_write}, 32'h0);
        check("mid_rst_write_reg", {27'b0, o_write_reg}, 32'h0);
        check("mid_rst_alu", o_alu_result, 32'h0);
        check("mid_rst_mem_data", o_mem_data, 32'h0);
        check("mid_rst_debug", o_debug_data, 32'h0);
        reset = 1'b0; wb_write = 1'b0; write_reg = 5'd0;
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h20, 32'h0);
        debug_addr = 8'd9;
        step();
        check("retained_after_rst", o_mem_data, 32'h0000_0077);
        check("rst_store_debug", o_debug_data, 32'h0);
        mem_op(1'b1, 1'b0, 1'b0, SZ_W, 32'h24, 32'h0);
        debug_addr = 8'd4;
        step();
        check("rst_store_suppressed", o_mem_data, 32'h0);
        check("retained_debug", o_debug_data, 32'h1234_5AEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
